// File: rtl/rtc_menu_pkg.sv
`default_nettype none
// ============================================================================
// rtc_menu_pkg : scan FSM state type and default RTC segment addresses
// Rev 1.0
// ============================================================================
package rtc_menu_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_WAIT  = 2'd3
  } scan_state_e;

  localparam logic [6:0] c_init_addr = 7'h02;
  localparam logic [6:0] c_s0_lo     = 7'h21;
  localparam logic [6:0] c_s0_hi     = 7'h27;
  localparam logic [6:0] c_s1_lo     = 7'h41;
  localparam logic [6:0] c_s1_hi     = 7'h44;

endpackage
`default_nettype wire

// File: rtl/rtc_pulse_timer.sv
`default_nettype none
// ============================================================================
// rtc_pulse_timer : on i_start, o_run is high for N cycles from the next one;
//                   o_last marks the final cycle. Starts while running are ignored.
// Rev 1.0
// ============================================================================
module rtc_pulse_timer #(
  parameter int N = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_start,
  output logic o_run,
  output logic o_last
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] r_cnt;
  logic          r_run;
  logic          r_last;
  logic [CW-1:0] w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + CW'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_last <= 1'b0;
    end else if (r_run) begin
      if (r_last) begin
        r_cnt  <= '0;
        r_run  <= 1'b0;
        r_last <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_nxt;
        r_last <= (w_cnt_nxt == CW'(N));
      end
    end else if (i_start) begin
      r_cnt  <= CW'(1);
      r_run  <= 1'b1;
      r_last <= (N == 1);
    end
  end

  assign o_run  = r_run;
  assign o_last = r_last;

endmodule
`default_nettype wire

// File: rtl/rtc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// rtc_scan_sequencer : drives the RTC access controller through an init access
//                      and repeating two-segment scans; edit pointer and alarm.
// Rev 1.0
// ============================================================================
module rtc_scan_sequencer
  import rtc_menu_pkg::*;
#(
  parameter int            AW        = 7,
  parameter logic [AW-1:0] INIT_ADDR = AW'(c_init_addr),
  parameter logic [AW-1:0] S0_LO     = AW'(c_s0_lo),
  parameter logic [AW-1:0] S0_HI     = AW'(c_s0_hi),
  parameter logic [AW-1:0] S1_LO     = AW'(c_s1_lo),
  parameter logic [AW-1:0] S1_HI     = AW'(c_s1_hi),
  parameter int            WAIT_CYC  = 5,
  parameter int            ALARM_CYC = 3,
  parameter int            TO_CYC    = 255
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_frw,
  input  logic          i_irq,
  input  logic          i_b_up,
  input  logic          i_b_dn,
  input  logic          i_b_left,
  input  logic          i_b_right,
  input  logic          i_b_ok,
  output logic [AW-1:0] o_dir,
  output logic          o_acc,
  output logic          o_mod,
  output logic [AW-1:0] o_punt,
  output logic          o_num_up,
  output logic          o_num_dn,
  output logic          o_alarm,
  output logic          o_stw,
  output logic          o_busy
);

  localparam int TOW = $clog2(TO_CYC + 1);

  scan_state_e   r_state;
  logic [AW-1:0] r_dir;
  logic          r_acc;
  logic          r_mod;
  logic          r_commit;
  logic [TOW-1:0] r_to;
  logic          r_init_pend;
  logic          r_busy;
  logic [AW-1:0] r_punt;
  logic          r_num_up;
  logic          r_num_dn;

  scan_state_e   w_state_nxt;
  logic [AW-1:0] w_dir_nxt;
  logic          w_acc_nxt;
  logic          w_mod_nxt;
  logic          w_commit_nxt;
  logic [TOW-1:0] w_to_nxt;
  logic          w_init_pend_nxt;
  logic          w_wait_start;
  logic          w_wait_run;
  logic          w_wait_last;
  logic          w_to_hit;
  logic [AW-1:0] w_punt_nxt;

  function automatic logic [AW-1:0] f_advance(input logic [AW-1:0] a);
    return (a == S0_HI) ? S1_LO : a + 1'b1;
  endfunction

  assign w_to_hit = (r_to == TOW'(TO_CYC - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_dir_nxt       = r_dir;
    w_acc_nxt       = 1'b0;
    w_mod_nxt       = r_mod;
    w_commit_nxt    = r_commit | i_b_ok;
    w_to_nxt        = '0;
    w_init_pend_nxt = r_init_pend;
    w_wait_start    = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_init_pend) begin
          w_acc_nxt       = 1'b1;
          w_init_pend_nxt = 1'b0;
        end else if (i_frw) begin
          w_dir_nxt   = S0_LO;
          w_state_nxt = ST_ISSUE;
        end else if (w_to_hit) begin
          w_acc_nxt = 1'b1;
        end else begin
          w_to_nxt = r_to + 1'b1;
        end
      end
      ST_ISSUE: begin
        w_acc_nxt   = 1'b1;
        w_state_nxt = ST_XFER;
      end
      ST_XFER: begin
        if (i_frw) begin
          if (r_dir == S1_HI) begin
            // a commit arriving on the closing cycle still makes the next scan a write
            w_dir_nxt    = S0_LO;
            w_mod_nxt    = r_commit | i_b_ok;
            w_commit_nxt = 1'b0;
            w_state_nxt  = ST_WAIT;
            w_wait_start = 1'b1;
          end else begin
            w_dir_nxt   = f_advance(r_dir);
            w_state_nxt = ST_ISSUE;
          end
        end else if (w_to_hit) begin
          w_acc_nxt = 1'b1;
        end else begin
          w_to_nxt = r_to + 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_wait_run && w_wait_last) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    w_punt_nxt = r_punt;
    if (i_b_ok) begin
      w_punt_nxt = S0_LO;
    end else if (i_b_left && !i_b_right) begin
      if (r_punt == S0_HI)      w_punt_nxt = S1_LO;
      else if (r_punt == S1_HI) w_punt_nxt = S0_LO;
      else                      w_punt_nxt = r_punt + 1'b1;
    end else if (i_b_right && !i_b_left) begin
      if (r_punt == S0_LO)      w_punt_nxt = S1_HI;
      else if (r_punt == S1_LO) w_punt_nxt = S0_HI;
      else                      w_punt_nxt = r_punt - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_INIT;
      r_dir       <= INIT_ADDR;
      r_acc       <= 1'b0;
      r_mod       <= 1'b1;
      r_commit    <= 1'b0;
      r_to        <= '0;
      r_init_pend <= 1'b1;
      r_busy      <= 1'b1;
      r_punt      <= S0_LO;
      r_num_up    <= 1'b0;
      r_num_dn    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dir       <= w_dir_nxt;
      r_acc       <= w_acc_nxt;
      r_mod       <= w_mod_nxt;
      r_commit    <= w_commit_nxt;
      r_to        <= w_to_nxt;
      r_init_pend <= w_init_pend_nxt;
      r_busy      <= (w_state_nxt != ST_WAIT);
      r_punt      <= w_punt_nxt;
      r_num_up    <= i_b_up & ~i_b_dn;
      r_num_dn    <= i_b_dn & ~i_b_up;
    end
  end

  rtc_pulse_timer #(.N(WAIT_CYC)) u_wait_tmr (
    .CLK     (CLK),
    .RST     (RST),
    .i_start (w_wait_start),
    .o_run   (w_wait_run),
    .o_last  (w_wait_last)
  );

  rtc_pulse_timer #(.N(ALARM_CYC)) u_alarm_tmr (
    .CLK     (CLK),
    .RST     (RST),
    .i_start (i_irq),
    .o_run   (o_alarm),
    .o_last  (o_stw)
  );

  assign o_dir    = r_dir;
  assign o_acc    = r_acc;
  assign o_mod    = r_mod;
  assign o_punt   = r_punt;
  assign o_num_up = r_num_up;
  assign o_num_dn = r_num_dn;
  assign o_busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rtc_scan_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_rtc_scan_sequencer : random + directed stimulus against a scan-list model
// Rev 1.0
// ============================================================================
module tb_rtc_scan_sequencer;

  localparam int         AW        = 7;
  localparam logic [6:0] INIT_ADDR = 7'h02;
  localparam logic [6:0] S0_LO     = 7'h21;
  localparam logic [6:0] S0_HI     = 7'h27;
  localparam logic [6:0] S1_LO     = 7'h41;
  localparam logic [6:0] S1_HI     = 7'h44;
  localparam int         WAIT_CYC  = 5;
  localparam int         ALARM_CYC = 3;
  localparam int         TO_CYC    = 255;

  localparam int M_INIT = 0, M_ISSUE = 1, M_XFER = 2, M_WAIT = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          frw = 1'b0, irq = 1'b0, b_up = 1'b0, b_dn = 1'b0;
  logic          b_left = 1'b0, b_right = 1'b0, b_ok = 1'b0;
  logic [AW-1:0] dir, punt;
  logic          acc, mod, num_up, num_dn, alarm, stw, busy;

  always #5 CLK = ~CLK;

  rtc_scan_sequencer #(
    .AW(AW), .INIT_ADDR(INIT_ADDR), .S0_LO(S0_LO), .S0_HI(S0_HI),
    .S1_LO(S1_LO), .S1_HI(S1_HI), .WAIT_CYC(WAIT_CYC),
    .ALARM_CYC(ALARM_CYC), .TO_CYC(TO_CYC)
  ) dut (
    .CLK(CLK), .RST(RST), .i_frw(frw), .i_irq(irq), .i_b_up(b_up), .i_b_dn(b_dn),
    .i_b_left(b_left), .i_b_right(b_right), .i_b_ok(b_ok),
    .o_dir(dir), .o_acc(acc), .o_mod(mod), .o_punt(punt), .o_num_up(num_up),
    .o_num_dn(num_dn), .o_alarm(alarm), .o_stw(stw), .o_busy(busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // reference: scan as an ordered address list, pointer as an index into it
  int seq[11];
  int m_st, m_idx, m_wait, m_silent, m_alarm_left, m_pidx;
  bit m_first, m_acc, m_mod, m_commit, m_up, m_dn;
  int frw_cnt;
  bit hold_frw;

  task automatic model_reset();
    m_st = M_INIT; m_idx = -1; m_wait = 0; m_silent = 0; m_alarm_left = 0;
    m_pidx = 0; m_first = 1; m_acc = 0; m_mod = 1; m_commit = 0;
    m_up = 0; m_dn = 0; frw_cnt = 0;
  endtask

  task automatic model_step(input bit f, input bit irq_i, input bit up, input bit dn,
                            input bit lf, input bit rt, input bit ok);
    bit nc;
    nc = m_commit | ok;
    m_acc = 0;
    case (m_st)
      M_INIT: begin
        if (m_first) begin
          m_acc = 1; m_first = 0;
        end else if (f) begin
          m_idx = 0; m_st = M_ISSUE; m_silent = 0;
        end else begin
          m_silent++;
          if (m_silent == TO_CYC) begin m_acc = 1; m_silent = 0; end
        end
      end
      M_ISSUE: begin
        m_acc = 1; m_st = M_XFER; m_silent = 0;
      end
      M_XFER: begin
        if (f) begin
          m_silent = 0;
          if (m_idx == 10) begin
            m_idx = 0; m_mod = m_commit | ok; nc = 0;
            m_st = M_WAIT; m_wait = WAIT_CYC;
          end else begin
            m_idx++; m_st = M_ISSUE;
          end
        end else begin
          m_silent++;
          if (m_silent == TO_CYC) begin m_acc = 1; m_silent = 0; end
        end
      end
      default: begin
        m_wait--;
        if (m_wait == 0) m_st = M_ISSUE;
      end
    endcase
    m_commit = nc;
    if (ok)             m_pidx = 0;
    else if (lf && !rt) m_pidx = (m_pidx + 1) % 11;
    else if (rt && !lf) m_pidx = (m_pidx + 10) % 11;
    m_up = up && !dn;
    m_dn = dn && !up;
    if (m_alarm_left > 0) m_alarm_left--;
    else if (irq_i)       m_alarm_left = ALARM_CYC;
  endtask

  task automatic compare_all();
    chk("dir",    int'(dir),    (m_idx < 0) ? int'(INIT_ADDR) : seq[m_idx]);
    chk("acc",    int'(acc),    int'(m_acc));
    chk("mod",    int'(mod),    int'(m_mod));
    chk("punt",   int'(punt),   seq[m_pidx]);
    chk("num_up", int'(num_up), int'(m_up));
    chk("num_dn", int'(num_dn), int'(m_dn));
    chk("alarm",  int'(alarm),  (m_alarm_left > 0) ? 1 : 0);
    chk("stw",    int'(stw),    (m_alarm_left == 1) ? 1 : 0);
    chk("busy",   int'(busy),   (m_st != M_WAIT) ? 1 : 0);
  endtask

  // called at a falling edge; drives one cycle of inputs and checks the result
  task automatic run_cycle(input bit up, input bit dn, input bit lf, input bit rt,
                           input bit ok, input bit irq_i);
    bit f;
    f = 0;
    if (!hold_frw) begin
      if (frw_cnt > 0) begin
        frw_cnt--;
        if (frw_cnt == 0) f = 1;
      end else if ($urandom_range(0, 39) == 0) begin
        f = 1;
      end
    end
    if (m_acc) frw_cnt = $urandom_range(1, 5);
    frw = f; irq = irq_i; b_up = up; b_dn = dn;
    b_left = lf; b_right = rt; b_ok = ok;
    model_step(f, irq_i, up, dn, lf, rt, ok);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int k, budget, hit, acc_seen, acc_at, alarm_len, stw_at;
    k = 0;
    for (int a = S0_LO; a <= S0_HI; a++) begin seq[k] = a; k++; end
    for (int a = S1_LO; a <= S1_HI; a++) begin seq[k] = a; k++; end
    hold_frw = 0;
    model_reset();

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    compare_all();
    RST = 1'b0;

    run_idle(250);

    // commit during idle gap between scans
    hit = 0;
    for (budget = 0; budget < 300 && !hit; budget++) begin
      run_idle(1);
      if (m_st == M_WAIT) hit = 1;
    end
    chk("reach_wait", hit, 1);
    run_cycle(0, 0, 0, 0, 1, 0);
    run_idle(200);

    // pointer wrap boundaries
    run_cycle(0, 0, 0, 0, 1, 0);
    run_cycle(0, 0, 0, 1, 0, 0);
    chk("punt_wrap_right", int'(punt), int'(S1_HI));
    run_cycle(0, 0, 1, 0, 0, 0);
    chk("punt_wrap_left", int'(punt), int'(S0_LO));
    for (int i = 0; i < 7; i++) run_cycle(0, 0, 1, 0, 0, 0);
    chk("punt_seg_jump", int'(punt), int'(S1_LO));
    run_cycle(0, 0, 1, 1, 0, 0);
    chk("punt_both_hold", int'(punt), int'(S1_LO));
    run_cycle(0, 0, 0, 1, 0, 0);
    chk("punt_seg_back", int'(punt), int'(S0_HI));
    run_cycle(1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 1500; i++)
      run_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0);

    // access timeout at address 23
    hit = 0;
    for (budget = 0; budget < 400 && !hit; budget++) begin
      run_idle(1);
      if (m_acc && m_idx == 2 && m_st == M_XFER) hit = 1;
    end
    chk("reach_dir23", hit, 1);
    hold_frw = 1;
    acc_seen = 0; acc_at = -1;
    for (int i = 1; i <= TO_CYC + 3; i++) begin
      run_idle(1);
      if (acc) begin acc_seen++; acc_at = i; end
    end
    chk("to_repulse_count", acc_seen, 1);
    chk("to_repulse_cycle", acc_at, TO_CYC);
    chk("to_dir_held", int'(dir), 'h23);
    hold_frw = 0;
    hit = 0;
    for (budget = 0; budget < 20 && !hit; budget++) begin
      run_idle(1);
      if (m_idx == 3) hit = 1;
    end
    chk("to_resume", hit, 1);
    chk("to_next_dir", int'(dir), 'h24);

    // alarm length and no retrigger
    hit = 0;
    for (budget = 0; budget < 20 && !hit; budget++) begin
      if (m_alarm_left == 0) hit = 1;
      else run_idle(1);
    end
    alarm_len = 0; stw_at = -1;
    for (int i = 0; i < 8; i++) begin
      run_cycle(0, 0, 0, 0, 0, (i == 0) || (i == 2) || (i == 3));
      if (alarm) alarm_len++;
      if (stw) stw_at = i;
    end
    chk("alarm_len", alarm_len, ALARM_CYC);
    chk("stw_pos", stw_at, ALARM_CYC - 1);

    // asynchronous reset in the middle of a transfer at 42
    hit = 0;
    for (budget = 0; budget < 400 && !hit; budget++) begin
      run_idle(1);
      if (m_st == M_XFER && m_idx == 8) hit = 1;
    end
    chk("reach_dir42", hit, 1);
    frw = 0; irq = 0; b_up = 0; b_dn = 0; b_left = 0; b_right = 0; b_ok = 0;
    RST = 1'b1;
    #1;
    chk("rst_dir", int'(dir), int'(INIT_ADDR));
    chk("rst_mod", int'(mod), 1);
    chk("rst_acc", int'(acc), 0);
    model_reset();
    @(negedge CLK);
    compare_all();
    RST = 1'b0;
    run_idle(300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
